// File: rtl/pea_cmd_scheduler_pkg.sv
// Shared types, constants and helpers for the polynomial evaluation accelerator.
package pea_pkg;

  localparam int unsigned CMD_W      = 16;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned MAX_DEGREE = 10;

  typedef enum logic [1:0] {
    OP_STP = 2'b00,
    OP_EVP = 2'b01,
    OP_RST = 2'b10,
    OP_BAD = 2'b11
  } opcode_t;

  localparam logic [WORD_W-1:0] ST_OK       = WORD_W'(0);
  localparam logic [WORD_W-1:0] ST_BADINSTR = WORD_W'(1);
  localparam logic [WORD_W-1:0] ST_UNSET    = WORD_W'(2);
  localparam logic [WORD_W-1:0] ST_TIMEOUT  = WORD_W'(3);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_WAIT_DATA,
    S_START,
    S_RUN,
    S_EMIT
  } sched_state_t;

  // Decoded fields of cmd_data[15:6]; the low six bits carry nothing.
  typedef struct packed {
    opcode_t    op;
    logic [2:0] a;
    logic [4:0] n;
  } cmd_t;

  typedef struct packed {
    logic [WORD_W-1:0] result;
    logic [WORD_W-1:0] status;
  } out_tok_t;

  // Ceiling log2; log2(1) = 0.
  function automatic int unsigned log2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pea_cmd_scheduler_if.sv
// Command-FIFO pop side and output-FIFO push side of the scheduler.
interface pea_cmd_scheduler_if;
  import pea_pkg::*;

  logic              cmd_valid;
  logic [CMD_W-1:0]  cmd_data;
  logic              cmd_ready;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_result;
  logic [WORD_W-1:0] out_status;

  modport master (
    output cmd_valid, cmd_data, out_ready,
    input  cmd_ready, out_valid, out_result, out_status
  );

  modport slave (
    input  cmd_valid, cmd_data, out_ready,
    output cmd_ready, out_valid, out_result, out_status
  );

endinterface

// File: rtl/pea_cmd_scheduler_watchdog.sv
// Run-time watchdog: cleared before a sub-FSM starts, counts while it runs.
module pea_watchdog
  import pea_pkg::*;
#(
  parameter int unsigned timeout_cycles = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  localparam int unsigned CW = (log2(timeout_cycles) < 1) ? 1 : log2(timeout_cycles);
  localparam logic [CW-1:0] LAST = CW'(timeout_cycles - 1);

  logic [CW-1:0] cnt;

  // Saturates at LAST so a stalled enable cannot wrap back to zero.
  always_ff @(posedge clk) begin
    if (rst)                        cnt <= '0;
    else if (clear)                 cnt <= '0;
    else if (enable && !expired_c)  cnt <= cnt + CW'(1);
  end

  assign expired_c = (cnt == LAST);

endmodule

// File: rtl/pea_cmd_scheduler.sv
// Instruction scheduler: pops commands, waits for data, runs one sub-FSM
// at a time under a watchdog and forwards EVP results to the output FIFO.
module pea_cmd_scheduler
  import pea_pkg::*;
#(
  parameter  int unsigned buffer_size    = 1024,
  parameter  int unsigned timeout_cycles = 4096,
  localparam int unsigned DW             = log2(buffer_size) + 1
) (
  input  logic                clk,
  input  logic                rst,
  pea_cmd_scheduler_if.slave  bus,
  input  logic [DW-1:0]       data_count,
  output logic                start_stp,
  output logic                start_evp,
  output logic                start_rst,
  input  logic                done_stp,
  input  logic                done_evp,
  input  logic                done_rst,
  output logic [2:0]          op_A,
  output logic [4:0]          op_N,
  input  logic [WORD_W-1:0]   evp_result,
  input  logic [WORD_W-1:0]   evp_status,
  output logic                busy
);

  sched_state_t  state_q, state_n;
  cmd_t          cmd_q, cmd_n;
  opcode_t       op_q, op_n;
  logic [2:0]    a_n;
  logic [4:0]    n_n;
  out_tok_t      tok_q, tok_n;
  logic          out_valid_q;
  logic          go_stp, go_evp, go_rst;
  logic          wd_clr_c, wd_en_c, expired_c;
  logic          done_c;
  logic [DW-1:0] need_c;
  logic          unused_cmd_bits;

  assign unused_cmd_bits = ^bus.cmd_data[5:0];

  pea_watchdog #(.timeout_cycles(timeout_cycles)) u_wd (
    .clk       (clk),
    .rst       (rst),
    .clear     (wd_clr_c),
    .enable    (wd_en_c),
    .expired_c (expired_c)
  );

  // Tokens required before launch and the done line of the active op.
  always_comb begin
    need_c = '0;
    done_c = 1'b0;
    case (op_q)
      OP_STP:  begin need_c = DW'({1'b0, op_N} + 6'd1); done_c = done_stp; end
      OP_EVP:  begin need_c = DW'(1);                   done_c = done_evp; end
      OP_RST:  done_c = done_rst;
      default: ;
    endcase
  end

  always_comb begin
    state_n  = state_q;
    cmd_n    = cmd_q;
    op_n     = op_q;
    a_n      = op_A;
    n_n      = op_N;
    tok_n    = tok_q;
    go_stp   = 1'b0;
    go_evp   = 1'b0;
    go_rst   = 1'b0;
    wd_clr_c = 1'b0;
    wd_en_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          cmd_n   = cmd_t'(bus.cmd_data[CMD_W-1:6]);
          state_n = S_DECODE;
        end
      end
      S_DECODE: begin
        op_n = cmd_q.op;
        a_n  = cmd_q.a;
        n_n  = cmd_q.n;
        if (cmd_q.op == OP_BAD || (cmd_q.op == OP_STP && 32'(cmd_q.n) > MAX_DEGREE)) begin
          tok_n   = '{result: '0, status: ST_BADINSTR};
          state_n = S_EMIT;
        end else begin
          state_n = S_WAIT_DATA;
        end
      end
      S_WAIT_DATA: begin
        if (data_count >= need_c) begin
          go_stp  = (op_q == OP_STP);
          go_evp  = (op_q == OP_EVP);
          go_rst  = (op_q == OP_RST);
          state_n = S_START;
        end
      end
      S_START: begin
        wd_clr_c = 1'b1;
        state_n  = S_RUN;
      end
      // A done in the expiry cycle takes priority over the timeout.
      S_RUN: begin
        wd_en_c = 1'b1;
        if (done_c) begin
          if (op_q == OP_EVP) begin
            tok_n   = '{result: evp_result, status: evp_status};
            state_n = S_EMIT;
          end else begin
            state_n = S_IDLE;
          end
        end else if (expired_c) begin
          tok_n   = '{result: '0, status: ST_TIMEOUT};
          state_n = S_EMIT;
        end
      end
      S_EMIT: begin
        if (bus.out_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      op_q        <= OP_STP;
      op_A        <= '0;
      op_N        <= '0;
      start_stp   <= 1'b0;
      start_evp   <= 1'b0;
      start_rst   <= 1'b0;
      tok_q       <= '{result: '0, status: ST_OK};
      out_valid_q <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_n;
      cmd_q       <= cmd_n;
      op_q        <= op_n;
      op_A        <= a_n;
      op_N        <= n_n;
      start_stp   <= go_stp;
      start_evp   <= go_evp;
      start_rst   <= go_rst;
      tok_q       <= tok_n;
      out_valid_q <= (state_n == S_EMIT);
      busy        <= (state_n != S_IDLE);
    end
  end

  // The pop strobe must land in the IDLE cycle itself, so it is decoded from state.
  assign bus.cmd_ready  = (state_q == S_IDLE) && bus.cmd_valid && !rst;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = tok_q.result;
  assign bus.out_status = tok_q.status;

endmodule

// File: tb/tb_pea_cmd_scheduler.sv
// Bench for pea_cmd_scheduler: vector table plus hand-written corner sequences,
// output tokens checked against a scoreboard queue.
module tb_pea_cmd_scheduler;
  import pea_pkg::*;

  localparam int unsigned TMO = 16;
  localparam int unsigned DW  = 11;

  logic           clk = 1'b0;
  logic           rst;
  logic [DW-1:0]  data_count;
  logic           start_stp, start_evp, start_rst;
  logic           done_stp, done_evp, done_rst;
  logic [2:0]     op_A;
  logic [4:0]     op_N;
  logic [31:0]    evp_result, evp_status;
  logic           busy;

  pea_cmd_scheduler_if bus ();

  pea_cmd_scheduler #(.buffer_size(1024), .timeout_cycles(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .data_count (data_count),
    .start_stp  (start_stp),
    .start_evp  (start_evp),
    .start_rst  (start_rst),
    .done_stp   (done_stp),
    .done_evp   (done_evp),
    .done_rst   (done_rst),
    .op_A       (op_A),
    .op_N       (op_N),
    .evp_result (evp_result),
    .evp_status (evp_status),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] cmd;
    logic [10:0] dcount;
    int          done_dly;   // 0: done withheld; k: k cycles after the start cycle
    logic [31:0] res;
    logic [31:0] st;
    logic [2:0]  exp_start;  // {stp, evp, rst}
    bit          exp_tok;
    logic [31:0] exp_res;
    logic [31:0] exp_st;
  } vec_t;

  vec_t     vecs [11];
  out_tok_t sb_q [$];
  out_tok_t mon_exp;
  int       nvec = 0;
  int       nmis = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] mk(input logic [1:0] op, input logic [2:0] a, input logic [4:0] n);
    return {op, a, n, 6'h2A};
  endfunction

  // Output monitor: every transfer pops one expected token.
  always @(negedge clk) begin
    #1;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        nvec++;
        nmis++;
        $display("FAIL unexpected_token: got result 0x%0h status 0x%0h, expected none at %0t",
                 bus.out_result, bus.out_status, $time);
      end else begin
        mon_exp = sb_q.pop_front();
        chk("token_result", bus.out_result, mon_exp.result);
        chk("token_status", bus.out_status, mon_exp.status);
      end
    end
  end

  task automatic issue(input logic [15:0] cmd);
    int n;
    n = 0;
    bus.cmd_data  = cmd;
    bus.cmd_valid = 1'b1;
    #1;
    while (!bus.cmd_ready && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("cmd_ready_seen", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk);
    chk("cmd_ready_one_cycle", 32'(bus.cmd_ready), 32'd0);
    bus.cmd_valid = 1'b0;
  endtask

  // Called in the cycle after cmd_ready; n counts edges since the cmd_ready cycle.
  task automatic wait_evt(output int n);
    n = 1;
    while (!(start_stp || start_evp || start_rst || bus.out_valid) && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk("return_idle", 32'(busy), 32'd0);
  endtask

  task automatic pulse_done(input logic [1:0] op, input logic [31:0] r, input logic [31:0] s);
    evp_result = r;
    evp_status = s;
    case (op)
      2'b00:   done_stp = 1'b1;
      2'b01:   done_evp = 1'b1;
      2'b10:   done_rst = 1'b1;
      default: ;
    endcase
    @(negedge clk);
    done_stp   = 1'b0;
    done_evp   = 1'b0;
    done_rst   = 1'b0;
    evp_result = '1;
    evp_status = '1;
  endtask

  task automatic run_vec(input vec_t v);
    logic [15:0] c;
    logic [1:0]  op;
    int          n;
    c          = v.cmd;
    op         = c[15:14];
    data_count = v.dcount;
    if (v.exp_tok) sb_q.push_back('{result: v.exp_res, status: v.exp_st});
    issue(c);
    wait_evt(n);
    chk("start_lines", 32'({start_stp, start_evp, start_rst}), 32'(v.exp_start));
    chk("op_A", 32'(op_A), 32'(c[13:11]));
    chk("op_N", 32'(op_N), 32'(c[10:6]));
    if (v.exp_start != 3'b000) begin
      chk("start_latency", 32'(n), 32'd3);
      @(negedge clk);
      chk("start_one_cycle", 32'({start_stp, start_evp, start_rst}), 32'd0);
      if (v.done_dly > 0) begin
        repeat (v.done_dly - 1) @(negedge clk);
        pulse_done(op, v.res, v.st);
        if (op == 2'b01) chk("evp_out_valid_next", 32'(bus.out_valid), 32'd1);
        else             chk("busy_after_done", 32'(busy), 32'd0);
      end
    end
    wait_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: bench exceeded its time limit at %0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;

    vecs[0]  = '{mk(2'b01, 3'd2, 5'd0),  11'd1,    5,  32'h155,       32'd0, 3'b010, 1'b1, 32'h155,       32'd0};
    vecs[1]  = '{mk(2'b00, 3'd1, 5'd3),  11'd4,    3,  32'd0,         32'd0, 3'b100, 1'b0, 32'd0,         32'd0};
    vecs[2]  = '{mk(2'b10, 3'd5, 5'd7),  11'd0,    2,  32'd0,         32'd0, 3'b001, 1'b0, 32'd0,         32'd0};
    vecs[3]  = '{mk(2'b11, 3'd3, 5'd4),  11'd5,    0,  32'd0,         32'd0, 3'b000, 1'b1, 32'd0,         32'd1};
    vecs[4]  = '{mk(2'b00, 3'd4, 5'd12), 11'd20,   0,  32'd0,         32'd0, 3'b000, 1'b1, 32'd0,         32'd1};
    vecs[5]  = '{mk(2'b00, 3'd6, 5'd10), 11'd11,   1,  32'd0,         32'd0, 3'b100, 1'b0, 32'd0,         32'd0};
    vecs[6]  = '{mk(2'b01, 3'd7, 5'd0),  11'd3,    2,  32'hDEADBEEF,  32'd2, 3'b010, 1'b1, 32'hDEADBEEF,  32'd2};
    vecs[7]  = '{mk(2'b01, 3'd0, 5'd0),  11'd1,    0,  32'd0,         32'd0, 3'b010, 1'b1, 32'd0,         32'd3};
    vecs[8]  = '{mk(2'b10, 3'd2, 5'd0),  11'd0,    0,  32'd0,         32'd0, 3'b001, 1'b1, 32'd0,         32'd3};
    vecs[9]  = '{mk(2'b01, 3'd1, 5'd0),  11'd1,    16, 32'h1234,      32'd0, 3'b010, 1'b1, 32'h1234,      32'd0};
    vecs[10] = '{mk(2'b00, 3'd3, 5'd31), 11'd2047, 0,  32'd0,         32'd0, 3'b000, 1'b1, 32'd0,         32'd1};

    rst           = 1'b1;
    data_count    = '0;
    done_stp      = 1'b0;
    done_evp      = 1'b0;
    done_rst      = 1'b0;
    evp_result    = '1;
    evp_status    = '1;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst_cmd_ready",  32'(bus.cmd_ready), 32'd0);
    chk("rst_start",      32'({start_stp, start_evp, start_rst}), 32'd0);
    chk("rst_out_valid",  32'(bus.out_valid), 32'd0);
    chk("rst_out_result", bus.out_result, 32'd0);
    chk("rst_out_status", bus.out_status, 32'd0);
    chk("rst_op_A",       32'(op_A), 32'd0);
    chk("rst_op_N",       32'(op_N), 32'd0);
    chk("rst_busy",       32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    // STP waits for N+1 = 4 data tokens while data_count climbs 2 -> 3 -> 4.
    data_count = 11'd2;
    issue(mk(2'b00, 3'd1, 5'd3));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stp_hold_dc2", 32'(start_stp), 32'd0);
    end
    data_count = 11'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stp_hold_dc3", 32'(start_stp), 32'd0);
      chk("stp_busy_wait", 32'(busy), 32'd1);
    end
    data_count = 11'd4;
    n = 0;
    while (!start_stp && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("stp_start_at_dc4", 32'(n), 32'd1);
    @(negedge clk);
    chk("stp_start_one_cycle", 32'(start_stp), 32'd0);
    pulse_done(2'b00, 32'd0, 32'd0);
    chk("stp_busy_low_next", 32'(busy), 32'd0);
    wait_idle();

    // EVP timeout under backpressure, with a late done and a pending command.
    bus.out_ready = 1'b0;
    data_count    = 11'd1;
    sb_q.push_back('{result: 32'd0, status: 32'd3});
    issue(mk(2'b01, 3'd4, 5'd0));
    wait_evt(n);
    chk("tmo_start_evp", 32'(start_evp), 32'd1);
    n = 0;
    while (!bus.out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_run_cycles", 32'(n - 1), 32'(TMO));
    pulse_done(2'b01, 32'h0BAD, 32'd0);
    bus.cmd_data  = mk(2'b01, 3'd5, 5'd0);
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("hold_out_valid",  32'(bus.out_valid), 32'd1);
      chk("hold_out_result", bus.out_result, 32'd0);
      chk("hold_out_status", bus.out_status, 32'd3);
      chk("hold_cmd_ready",  32'(bus.cmd_ready), 32'd0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    sb_q.push_back('{result: 32'h77, status: 32'd0});
    issue(mk(2'b01, 3'd5, 5'd0));
    wait_evt(n);
    chk("pending_start_evp", 32'(start_evp), 32'd1);
    @(negedge clk);
    pulse_done(2'b01, 32'h77, 32'd0);
    wait_idle();

    // Done in the start cycle and done on the wrong lines are both ignored.
    sb_q.push_back('{result: 32'd0, status: 32'd3});
    data_count = 11'd1;
    issue(mk(2'b01, 3'd3, 5'd0));
    wait_evt(n);
    chk("ign_start_evp", 32'(start_evp), 32'd1);
    done_evp = 1'b1;
    @(negedge clk);
    done_evp = 1'b0;
    done_stp = 1'b1;
    done_rst = 1'b1;
    @(negedge clk);
    done_stp = 1'b0;
    done_rst = 1'b0;
    wait_idle();

    // Reset in RUN drops the command; the next command runs normally.
    data_count = 11'd1;
    issue(mk(2'b01, 3'd6, 5'd9));
    wait_evt(n);
    repeat (3) @(negedge clk);
    chk("mid_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_cmd_ready",  32'(bus.cmd_ready), 32'd0);
    chk("mid_rst_start",      32'({start_stp, start_evp, start_rst}), 32'd0);
    chk("mid_rst_out_valid",  32'(bus.out_valid), 32'd0);
    chk("mid_rst_out_result", bus.out_result, 32'd0);
    chk("mid_rst_out_status", bus.out_status, 32'd0);
    chk("mid_rst_op_A",       32'(op_A), 32'd0);
    chk("mid_rst_op_N",       32'(op_N), 32'd0);
    chk("mid_rst_busy",       32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    run_vec(vecs[0]);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/pea_cmd_scheduler.md
# pea_cmd_scheduler

Top-level instruction scheduler for the polynomial evaluation accelerator. It pops 16-bit instruction tokens from the command FIFO and decodes them into STP (set polynomial), EVP (evaluate) or RST (clear polynomial) operations. It waits until the data FIFO holds enough tokens, then launches exactly one sub-FSM with a start/done handshake, guarded by a watchdog. It forwards EVP result/status words to the output FIFO under valid/ready backpressure.

## Interface
Parameters:
- buffer_size, 1024, depth of the data FIFO; sets width DW = log2(buffer_size)+1 of data_count
- timeout_cycles, 4096, maximum cycles a sub-FSM may run before it is abandoned

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset; one clock, sampled on the rising edge of clk
- cmd_valid  in  1  command FIFO non-empty
- cmd_data  in  16  instruction: [15:14] opcode (00 STP, 01 EVP, 10 RST, 11 invalid), [13:11] A, [10:6] N, [5:0] ignored
- cmd_ready  out  1  one-cycle pop strobe to the command FIFO
- data_count  in  DW  tokens currently in the data FIFO
- start_stp / start_evp / start_rst  out  1  one-cycle start pulses
- done_stp / done_evp / done_rst  in  1  completion pulses from the sub-FSMs
- op_A  out  3  latched polynomial index, held stable for the whole operation
- op_N  out  5  latched degree (STP only), held stable
- evp_result  in  32  EVP result, valid in the cycle done_evp is high
- evp_status  in  32  EVP status, valid in the cycle done_evp is high
- out_valid  out  1  output token pending
- out_ready  in  1  output FIFO can accept
- out_result  out  32  result word
- out_status  out  32  status word: 0 ok, 1 bad instruction, 2 polynomial unset (from EVP), 3 timeout
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, DECODE, WAIT_DATA, START, RUN, EMIT.
- IDLE: if cmd_valid, pulse cmd_ready and register cmd_data, then go to DECODE.
- DECODE: latch op_A and op_N.
  - Opcode 11 -> EMIT with {result 0, status 1}.
  - STP with N > 10 -> EMIT with {0, 1}.
  - Otherwise -> WAIT_DATA.
- WAIT_DATA: wait until data_count ≥ need, then go to START.
  - STP: need = N+1.
  - EVP: need = 1.
  - RST: need = 0, so it passes through in one cycle.
- START: pulse the start line matching the opcode, clear the watchdog, go to RUN.
- RUN: watchdog increments each cycle.
  - done of the active op -> EVP captures evp_result/evp_status and goes to EMIT; STP/RST go to IDLE (no output token).
  - Watchdog reaching timeout_cycles-1 with no done -> EMIT with {0, 3}, for every opcode.
- EMIT: hold out_valid with stable out_result/out_status. A transfer occurs on the edge where out_valid && out_ready; out_valid drops and the FSM goes to IDLE.
- A done pulse on a line other than the active one, or outside RUN, is ignored.
- A done arriving in the same cycle as the watchdog expiry counts as done (normal completion wins).
- A done arriving after a timeout is ignored.
- Arithmetic: the need comparison is unsigned at DW bits. N+1 is computed at 6 bits and zero-extended.

## Timing
- Reset values: cmd_ready 0, start_* 0, out_valid 0, out_result 0, out_status 0, op_A 0, op_N 0, busy 0, state IDLE, watchdog 0.
- Reset mid-operation: the next edge returns everything to reset values and the in-flight command is dropped. Sub-FSMs are reset by the same rst.
- cmd_ready is high for exactly one cycle per instruction and never while busy.
- Edge count from the cmd_ready cycle to the start pulse: DECODE +1, WAIT_DATA ≥1, START +1. Minimum latency is 3 edges.
- The start_* pulse is exactly one cycle long. A done in the same cycle as start is ignored, since RUN begins on the next edge.
- EVP done -> out_valid on the next edge.
- Throughput: after an EMIT transfer or an STP/RST done, IDLE can pop the next command on the following edge.
- out_result and out_status are stable while out_valid && !out_ready.

## Structure
- Shared package pea_pkg holds:
  - opcode constants OP_STP/OP_EVP/OP_RST/OP_BAD
  - status codes ST_OK/ST_BADINSTR/ST_UNSET/ST_TIMEOUT
  - scheduler state encoding
  - the log2 function
  - MAX_DEGREE = 10
- One sub-module, pea_watchdog: clear/enable counter with an expired flag, parameterised by timeout_cycles.

## Test plan
- EVP, A=2, data_count=1; done_evp 5 cycles after start with result 0x0000_0155, status 0 -> one output token {0x155, 0}; start_evp high exactly 1 cycle.
- STP, A=1, N=3, data_count rising 2→4 -> start_stp fires only once data_count=4; done_stp -> no output token; busy low the next cycle.
- Opcode 11, and STP with N=12 -> no start pulse; output {0, 1}.
- EVP with done_evp withheld, timeout_cycles=16 -> output {0, 3} at 16 cycles in RUN; a late done_evp is ignored.
- out_ready held low 10 cycles in EMIT -> out_valid and data stable, cmd_ready stays low despite cmd_valid; transfer on release.
- rst asserted during RUN -> all outputs at reset values next edge; the next command is processed normally.
